// File: rtl/pipe_arb.sv
// pipe_arb: arbitrates two requesters onto a 4-stage pipe, tracks issued ops
// in an in-order tag FIFO and routes each pipe result back to its requester.
// Optional feature: define PIPE_ARB_RR_EN for round-robin arbitration;
// without it r0 always has priority over r1.
module pipe_arb #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_vld,
  input  logic       r1_vld,
  output logic       r0_rdy,
  output logic       r1_rdy,
  input  logic [1:0] r0_data,
  input  logic [1:0] r1_data,
  input  logic       r0_action,
  input  logic       r1_action,
  output logic       p_in_vld,
  output logic [1:0] p_data,
  output logic       p_action,
  input  logic       p_out_vld,
  input  logic [1:0] p_out,
  output logic       rsp_vld,
  output logic       rsp_id,
  output logic [1:0] rsp_data,
  input  logic       drain,
  output logic       drain_done,
  output logic       err
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;
  localparam logic [2:0] MAX_Q    = 3'(MAX_INFLIGHT);

  logic [1:0] state_q, state_d;
  logic [2:0] inflight_q, inflight_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic       err_q, err_d;
  logic       p_in_vld_q;
  logic [1:0] p_data_q;
  logic       p_action_q;
  logic       tag_q [4];

  logic open, gnt0, gnt1, accept, fifo_empty, pop;

  // Grant window: only while running, out of reset, and below the in-flight cap.
  // The cap uses the registered count, so a same-cycle return never re-opens it.
  assign open = rst && (state_q == ST_RUN) && (inflight_q < MAX_Q);

`ifdef PIPE_ARB_RR_EN
  // rr_q=1 means r1 currently holds priority; the last winner drops to lowest.
  logic rr_q;

  assign gnt0 = open && r0_vld && (!r1_vld || !rr_q);
  assign gnt1 = open && r1_vld && (!r0_vld || rr_q);

  // Every grant, contested or not, hands priority to the other requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= 1'b0;
    end else if (accept) begin
      rr_q <= !gnt1;
    end
  end
`else
  assign gnt0 = open && r0_vld;
  assign gnt1 = open && r1_vld && !r0_vld;
`endif

  assign accept = gnt0 || gnt1;
  assign r0_rdy = gnt0;
  assign r1_rdy = gnt1;

  // The tag FIFO and the in-flight counter move together, so an empty FIFO
  // is simply a zero count; a result arriving then is an orphan, not a pop.
  assign fifo_empty = (inflight_q == 3'd0);
  assign pop        = p_out_vld && !fifo_empty;

  assign rsp_vld    = p_out_vld;
  assign rsp_data   = p_out;
  assign rsp_id     = tag_q[rd_ptr_q];

  assign p_in_vld   = p_in_vld_q;
  assign p_data     = p_data_q;
  assign p_action   = p_action_q;
  assign err        = err_q;
  assign drain_done = (state_q == ST_IDLE);

  // Next-state for counter, FIFO pointers (wrap modulo 4) and sticky error.
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !pop) begin
      inflight_d = inflight_q + 3'd1;
    end else if (!accept && pop) begin
      inflight_d = inflight_q - 3'd1;
    end
    wr_ptr_d = accept ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
    err_d    = err_q || (p_out_vld && fifo_empty);
  end

  // Drain sequencing: stop granting, wait for the pipe to empty, then hold
  // in IDLE until drain is released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain) state_d = ST_DRAIN;
      ST_DRAIN: if (inflight_d == 3'd0) state_d = ST_IDLE;
      ST_IDLE:  if (!drain) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Control state and the pipe input register; payload holds between accepts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      inflight_q <= 3'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      err_q      <= 1'b0;
      p_in_vld_q <= 1'b0;
      p_data_q   <= 2'd0;
      p_action_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
      p_in_vld_q <= accept;
      if (accept) begin
        p_data_q   <= gnt1 ? r1_data : r0_data;
        p_action_q <= gnt1 ? r1_action : r0_action;
      end
    end
  end

  // Tag storage: entries are only meaningful between write and read pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q[wr_ptr_q] <= gnt1;
    end
  end

endmodule
